// File: rtl/axi_store_buffer_if.sv
// AXI write-channel bundle (AW/W/B) between the store buffer and the bus.
//   master : store buffer side, drives AW/W payload + valids and bready
//   slave  : interconnect side, drives awready/wready and the B channel
interface axi_store_buffer_if;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_store_buffer.sv
// Posted write buffer for uncached single-word stores.
// Stores are accepted in one cycle into a circular FIFO and drained in order
// as single-beat AXI writes. The head entry stays buffered until its B
// response arrives, so hazard checks cover in-flight stores too.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   st_valid/st_ready    store request handshake from the cache
//   st_addr/data/strb    store byte address, lane-aligned data, byte enables
//   chk_addr / chk_hit   load address probe; hit if a buffered word matches
//   empty                nothing buffered or in flight
//   axi                  AXI write channels (master modport)
module axi_store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter logic [3:0]  AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_strb,
  input  logic [31:0] chk_addr,
  output logic        chk_hit,
  output logic        empty,
  axi_store_buffer_if.master axi
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE_CNT  = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

  state_t state_q, state_d;
  logic   awvalid_q, awvalid_d;
  logic   wvalid_q, wvalid_d;
  logic   bready_q, bready_d;

  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic [DEPTH-1:0] valid_q;
  logic [31:0]    addr_q [DEPTH];
  logic [31:0]    data_q [DEPTH];
  logic [3:0]     strb_q [DEPTH];

  logic push, pop;
  logic [DEPTH-1:0] hit_vec;

  assign st_ready = (count != FULL_CNT);
  assign empty    = (count == '0);
  assign push     = st_valid && st_ready;
  assign pop      = (state_q == RESP) && axi.bvalid && bready_q;

  // FIFO bookkeeping
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      if (push) begin
        wr_ptr          <= wr_ptr + 1'b1;
        valid_q[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr          <= rd_ptr + 1'b1;
        valid_q[rd_ptr] <= 1'b0;
      end
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  // Entry payload needs no reset; valid_q qualifies it.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= st_addr;
      data_q[wr_ptr] <= st_data;
      strb_q[wr_ptr] <= st_strb;
    end
  end

  // Issue FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    unique case (state_q)
      IDLE: begin
        if (count != '0) begin
          state_d   = SEND;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end
      end
      SEND: begin
        // AW and W complete independently; a channel stays low once done.
        awvalid_d = awvalid_q && !axi.awready;
        wvalid_d  = wvalid_q && !axi.wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = RESP;
          bready_d = 1'b1;
        end
      end
      RESP: begin
        if (pop) begin
          bready_d = 1'b0;
          // Entries left after this pop, including a same-cycle push.
          if (count > ONE_CNT || push) begin
            state_d   = SEND;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
      end
    endcase
  end

  // Hazard detection over every valid entry, including the in-flight head
  for (genvar g = 0; g < DEPTH; g++) begin : g_hit
    assign hit_vec[g] = valid_q[g] && (addr_q[g][31:2] == chk_addr[31:2]);
  end
  assign chk_hit = |hit_vec;

  // AXI outputs
  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = addr_q[rd_ptr];
  assign axi.awlen   = '0;
  assign axi.awsize  = 3'b010;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = '0;
  assign axi.awcache = '0;
  assign axi.awprot  = '0;
  assign axi.awvalid = awvalid_q;
  assign axi.wid     = AXI_ID;
  assign axi.wdata   = data_q[rd_ptr];
  assign axi.wstrb   = strb_q[rd_ptr];
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;

  // Response ID/status and the byte offset of the probe are not needed.
  logic unused_bits;
  assign unused_bits = ^{axi.bid, axi.bresp, chk_addr[1:0]};

endmodule

// File: tb/tb_axi_store_buffer.sv
module tb_axi_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_strb;
  logic [31:0] chk_addr;
  logic        chk_hit;
  logic        empty;

  axi_store_buffer_if axi ();

  axi_store_buffer #(.DEPTH(DEPTH), .AXI_ID(4'd1)) dut (
    .clk(clk), .rstn(rstn),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_strb(st_strb),
    .chk_addr(chk_addr), .chk_hit(chk_hit), .empty(empty),
    .axi(axi.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: the ordered list of stores the buffer owns, from
  // acceptance until their write response.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } st_t;
  st_t q[$];
  int n_drained = 0;
  int aw_beats = 0;
  int w_beats = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q.delete();
      aw_beats = 0;
      w_beats = 0;
    end else begin
      if (axi.awvalid) begin
        total++;
        if (q.size() == 0 || axi.awaddr !== q[0].addr) begin
          bad++;
          $display("FAIL awaddr got=%h exp=%h qsize=%0d", axi.awaddr,
                   (q.size() != 0) ? q[0].addr : 32'h0, q.size());
        end
      end
      if (axi.wvalid) begin
        total++;
        if (q.size() == 0 || {axi.wdata, axi.wstrb} !== {q[0].data, q[0].strb}) begin
          bad++;
          $display("FAIL wdata got=%h/%h exp=%h/%h", axi.wdata, axi.wstrb,
                   (q.size() != 0) ? q[0].data : 32'h0, (q.size() != 0) ? q[0].strb : 4'h0);
        end
      end
      if (axi.awvalid && axi.awready) aw_beats++;
      if (axi.wvalid && axi.wready) w_beats++;
      if (axi.bvalid && axi.bready) begin
        total++;
        if (aw_beats != 1 || w_beats != 1 || q.size() == 0) begin
          bad++;
          $display("FAIL beats got aw=%0d w=%0d qsize=%0d exp aw=1 w=1 qsize>0",
                   aw_beats, w_beats, q.size());
        end
        if (q.size() != 0) void'(q.pop_front());
        n_drained++;
        aw_beats = 0;
        w_beats = 0;
      end
      if (st_valid && st_ready) q.push_back(st_t'{st_addr, st_data, st_strb});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic slave(input logic awr, input logic wr, input logic bv);
    axi.awready = awr;
    axi.wready  = wr;
    axi.bvalid  = bv;
  endtask

  task automatic wait_empty(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (empty) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_strb  = s;
  endtask

  task automatic test_reset();
    bit ok;
    int d0;
    rstn = 1'b0;
    st_valid = 1'b1;
    st_addr = 32'h0000_0040;
    st_data = 32'h1111_2222;
    st_strb = 4'hF;
    chk_addr = 32'h0000_0040;
    axi.bid = 4'd0;
    axi.bresp = 2'b00;
    slave(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    total++;
    if ({st_ready, axi.awvalid, axi.wvalid, axi.bready, empty, chk_hit} !== 6'b100010) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=100010",
               {st_ready, axi.awvalid, axi.wvalid, axi.bready, empty, chk_hit});
    end
    d0 = n_drained;
    rstn = 1'b1;
    @(negedge clk);
    st_valid = 1'b0;
    total++;
    if ({empty, chk_hit} !== 2'b01) begin
      bad++;
      $display("FAIL first_push_after_reset got=%b exp=01", {empty, chk_hit});
    end
    slave(1'b1, 1'b1, 1'b1);
    wait_empty(50, ok);
    total++;
    if (!ok || n_drained - d0 != 1) begin
      bad++;
      $display("FAIL reset_drain got ok=%0d n=%0d exp ok=1 n=1", ok, n_drained - d0);
    end
  endtask

  task automatic test_single();
    slave(1'b1, 1'b1, 1'b1);
    push_store(32'h1FD0_F010, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    st_valid = 1'b0;
    total++;
    if (axi.awvalid !== 1'b0) begin
      bad++;
      $display("FAIL single_t1_awvalid got=%b exp=0", axi.awvalid);
    end
    @(negedge clk);
    total++;
    if ({axi.awvalid, axi.wvalid, axi.wlast} !== 3'b111) begin
      bad++;
      $display("FAIL single_t2_valids got=%b exp=111", {axi.awvalid, axi.wvalid, axi.wlast});
    end
    total++;
    if ({axi.awaddr, axi.wdata, axi.wstrb} !== {32'h1FD0_F010, 32'hDEAD_BEEF, 4'hF}) begin
      bad++;
      $display("FAIL single_payload got=%h/%h/%h exp=1fd0f010/deadbeef/f",
               axi.awaddr, axi.wdata, axi.wstrb);
    end
    total++;
    if ({axi.awid, axi.wid, axi.awlen, axi.awsize, axi.awburst, axi.awlock, axi.awcache, axi.awprot}
        !== {4'd1, 4'd1, 8'd0, 3'b010, 2'b01, 2'b00, 4'd0, 3'd0}) begin
      bad++;
      $display("FAIL single_consts got id=%h wid=%h len=%h size=%b burst=%b lock=%b cache=%h prot=%h",
               axi.awid, axi.wid, axi.awlen, axi.awsize, axi.awburst, axi.awlock, axi.awcache, axi.awprot);
    end
    @(negedge clk);
    total++;
    if ({axi.bready, axi.awvalid, axi.wvalid, empty} !== 4'b1000) begin
      bad++;
      $display("FAIL single_resp got=%b exp=1000", {axi.bready, axi.awvalid, axi.wvalid, empty});
    end
    @(negedge clk);
    total++;
    if ({empty, axi.bready, axi.awvalid} !== 3'b100) begin
      bad++;
      $display("FAIL single_empty got=%b exp=100", {empty, axi.bready, axi.awvalid});
    end
  endtask

  task automatic test_fill();
    bit ok;
    int d0;
    slave(1'b0, 1'b0, 1'b0);
    d0 = n_drained;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      total++;
      if (st_ready !== 1'b1) begin
        bad++;
        $display("FAIL fill_ready_%0d got=%b exp=1", i, st_ready);
      end
      st_valid = 1'b1;
      st_addr  = 32'h0000_3000 + 32'(i * 16);
      st_data  = $urandom;
      st_strb  = 4'($urandom);
    end
    @(negedge clk);
    st_addr = 32'h0000_3F00;
    st_data = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({st_ready, axi.awvalid} !== 2'b01) begin
        bad++;
        $display("FAIL fill_full_%0d got=%b exp=01", i, {st_ready, axi.awvalid});
      end
      @(negedge clk);
    end
    st_valid = 1'b0;
    slave(1'b1, 1'b1, 1'b1);
    wait_empty(100, ok);
    total++;
    if (!ok || n_drained - d0 != DEPTH) begin
      bad++;
      $display("FAIL fill_drain got ok=%0d n=%0d exp ok=1 n=%0d", ok, n_drained - d0, DEPTH);
    end
  endtask

  task automatic test_w_first();
    bit found;
    slave(1'b0, 1'b0, 1'b0);
    push_store(32'h0000_5000, 32'hA5A5_0F0F, 4'h3);
    @(negedge clk);
    st_valid = 1'b0;
    axi.wready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (axi.awvalid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL wfirst_awvalid got=timeout exp=awvalid");
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({axi.wvalid, axi.awvalid, axi.bready} !== 3'b010) begin
        bad++;
        $display("FAIL wfirst_hold_%0d got=%b exp=010", i, {axi.wvalid, axi.awvalid, axi.bready});
      end
    end
    axi.awready = 1'b1;
    @(negedge clk);
    total++;
    if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b001) begin
      bad++;
      $display("FAIL wfirst_resp got=%b exp=001", {axi.awvalid, axi.wvalid, axi.bready});
    end
    axi.bvalid = 1'b1;
    @(negedge clk);
    total++;
    if (empty !== 1'b1) begin
      bad++;
      $display("FAIL wfirst_empty got=%b exp=1", empty);
    end
    slave(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_hazard();
    bit ok;
    bit found;
    int d0;
    slave(1'b0, 1'b0, 1'b0);
    push_store(32'h0000_1000, $urandom, 4'hF);
    push_store(32'h0000_2004, $urandom, 4'hF);
    @(negedge clk);
    st_valid = 1'b0;
    chk_addr = 32'h0000_1002;
    #1;
    total++;
    if (chk_hit !== 1'b1) begin
      bad++;
      $display("FAIL hazard_1002 got=%b exp=1", chk_hit);
    end
    chk_addr = 32'h0000_2008;
    #1;
    total++;
    if (chk_hit !== 1'b0) begin
      bad++;
      $display("FAIL hazard_2008 got=%b exp=0", chk_hit);
    end
    chk_addr = 32'h0000_2007;
    #1;
    total++;
    if (chk_hit !== 1'b1) begin
      bad++;
      $display("FAIL hazard_2007 got=%b exp=1", chk_hit);
    end
    d0 = n_drained;
    slave(1'b1, 1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (n_drained == d0 + 1) begin
        found = 1'b1;
        break;
      end
    end
    axi.bvalid = 1'b0;
    total++;
    if (!found) begin
      bad++;
      $display("FAIL hazard_first_b got=timeout exp=one_response");
    end
    chk_addr = 32'h0000_1002;
    #1;
    total++;
    if (chk_hit !== 1'b0) begin
      bad++;
      $display("FAIL hazard_after_b_1002 got=%b exp=0", chk_hit);
    end
    chk_addr = 32'h0000_2004;
    #1;
    total++;
    if (chk_hit !== 1'b1) begin
      bad++;
      $display("FAIL hazard_after_b_2004 got=%b exp=1", chk_hit);
    end
    axi.bvalid = 1'b1;
    wait_empty(50, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL hazard_drain got=timeout exp=empty");
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit found;
    int d0;
    slave(1'b0, 1'b0, 1'b0);
    d0 = n_drained;
    for (int i = 0; i < DEPTH; i++)
      push_store(32'h0000_6000 + 32'(i * 4), $urandom, 4'($urandom));
    @(negedge clk);
    st_valid = 1'b0;
    axi.awready = 1'b1;
    axi.wready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi.bready) begin
        found = 1'b1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL b2b_bready got=timeout exp=bready");
    end
    st_valid = 1'b1;
    st_addr = 32'h7777_0000;
    st_data = 32'h0BAD_0BAD;
    st_strb = 4'hF;
    axi.bvalid = 1'b1;
    axi.bresp = 2'b10;
    #1;
    total++;
    if (st_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_full_ready got=%b exp=0", st_ready);
    end
    @(negedge clk);
    st_valid = 1'b0;
    axi.bvalid = 1'b0;
    axi.bresp = 2'b00;
    total++;
    if ({st_ready, axi.awvalid, axi.wvalid, axi.bready} !== 4'b1110 || n_drained - d0 != 1) begin
      bad++;
      $display("FAIL b2b_next got=%b n=%0d exp=1110 n=1",
               {st_ready, axi.awvalid, axi.wvalid, axi.bready}, n_drained - d0);
    end
    axi.bvalid = 1'b1;
    wait_empty(100, ok);
    total++;
    if (!ok || n_drained - d0 != DEPTH) begin
      bad++;
      $display("FAIL b2b_drain got ok=%0d n=%0d exp ok=1 n=%0d", ok, n_drained - d0, DEPTH);
    end
  endtask

  task automatic test_random();
    bit ok;
    bit exp_hit;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      st_valid = 1'($urandom);
      st_addr  = 32'h0000_8000 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      st_data  = $urandom;
      st_strb  = 4'($urandom);
      axi.awready = 1'($urandom);
      axi.wready  = 1'($urandom);
      axi.bvalid  = 1'($urandom);
      axi.bresp   = 2'($urandom);
      chk_addr = 32'h0000_8000 | (32'($urandom_range(0, 9)) << 2) | 32'($urandom_range(0, 3));
      #1;
      exp_hit = 1'b0;
      foreach (q[k])
        if (q[k].addr[31:2] == chk_addr[31:2]) exp_hit = 1'b1;
      total++;
      if (chk_hit !== exp_hit) begin
        bad++;
        $display("FAIL rand_hit cyc=%0d got=%b exp=%b", cyc, chk_hit, exp_hit);
      end
      total++;
      if ({empty, st_ready} !== {q.size() == 0, q.size() != DEPTH}) begin
        bad++;
        $display("FAIL rand_level cyc=%0d got=%b exp=%b%b", cyc, {empty, st_ready},
                 q.size() == 0, q.size() != DEPTH);
      end
    end
    st_valid = 1'b0;
    axi.bresp = 2'b00;
    slave(1'b1, 1'b1, 1'b1);
    wait_empty(100, ok);
    total++;
    if (!ok || q.size() != 0) begin
      bad++;
      $display("FAIL rand_drain got ok=%0d qsize=%0d exp ok=1 qsize=0", ok, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_w_first();
    test_hazard();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
